mem_responder_16x16: RTL and testbench

MEM_RESPONDER_16X16 -- requirements
Module: mem_responder_16x16

---
 rtl/mem_responder_16x16.sv | 170 +++++++++++++++++
 tb/tb_mem_responder_16x16.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_16x16.sv
// 16x16 single-port memory responder with a post-reset init sweep.
// Ports: clk_g/rst_n; mem_ena/wea/addra/dina -> mem_douta; ready, wr_cnt, rd_cnt, err.
module mem_responder_16x16 #(
  parameter logic [15:0] INIT_VAL    = 16'h0000,
  parameter bit          WRITE_FIRST = 1'b0
) (
  input  logic        clk_g,
  input  logic        rst_n,
  input  logic        mem_ena,
  input  logic        mem_wea,
  input  logic [3:0]  mem_addra,
  input  logic [15:0] mem_dina,
  output logic [15:0] mem_douta,
  output logic        ready,
  output logic [7:0]  wr_cnt,
  output logic [7:0]  rd_cnt,
  output logic        err
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_PTR = 4'd15;
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  init_ptr_q;
  logic [15:0] douta_q;
  logic        ready_q;
  logic [7:0]  wr_cnt_q;
  logic [7:0]  rd_cnt_q;
  logic        err_q;

  logic [15:0] mem [16];

  logic        mem_we;
  logic [3:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        rd_acc;
  logic        wr_acc;
  logic        err_set;
  logic        init_adv;
  logic [15:0] rd_word;

  // State register
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; RUN is only left through reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: begin
        if (init_ptr_q == LAST_PTR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Output decode
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = init_ptr_q;
    mem_wdata = INIT_VAL;
    rd_acc    = 1'b0;
    wr_acc    = 1'b0;
    err_set   = 1'b0;
    init_adv  = 1'b0;
    unique case (state_q)
      INIT: begin
        mem_we   = 1'b1;
        init_adv = 1'b1;
        err_set  = mem_ena;
      end
      RUN: begin
        rd_acc    = mem_ena & ~mem_wea;
        wr_acc    = mem_ena & mem_wea;
        mem_we    = mem_ena & mem_wea;
        mem_waddr = mem_addra;
        mem_wdata = mem_dina;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Storage has no reset; writes are blocked while rst_n is low so a
  // reset landing on an access never completes it.
  always_ff @(posedge clk_g) begin
    if (mem_we && rst_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_word = mem[mem_addra];

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      init_ptr_q <= 4'd0;
    end else if (init_adv) begin
      init_ptr_q <= init_ptr_q + 4'd1;
    end
  end

  // Read data: old word on reads and read-first writes
  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= 16'h0000;
    end else if (rd_acc) begin
      douta_q <= rd_word;
    end else if (wr_acc) begin
      douta_q <= WRITE_FIRST ? mem_dina : rd_word;
    end
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else if (state_d == RUN) begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= 8'd0;
    end else if (wr_acc && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_q <= wr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 8'd0;
    end else if (rd_acc && (rd_cnt_q != CNT_MAX)) begin
      rd_cnt_q <= rd_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign mem_douta = douta_q;
  assign ready     = ready_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_cnt    = rd_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder_16x16.sv
// Directed bench for mem_responder_16x16: two instances, read-first with
// INIT_VAL 0 and write-first with INIT_VAL 16'h1234, on shared stimulus.
module tb_mem_responder_16x16;

  localparam logic [15:0] IV0 = 16'h0000;
  localparam logic [15:0] IV1 = 16'h1234;

  logic        clk_g = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_ena = 1'b0;
  logic        mem_wea = 1'b0;
  logic [3:0]  mem_addra = 4'd0;
  logic [15:0] mem_dina = 16'h0000;

  logic [15:0] douta0, douta1;
  logic        ready0, ready1;
  logic [7:0]  wr0, wr1, rd0, rd1;
  logic        err0, err1;

  int errors = 0;
  int checks = 0;

  always #5 clk_g = ~clk_g;

  mem_responder_16x16 #(.INIT_VAL(IV0), .WRITE_FIRST(1'b0)) dut0 (
    .clk_g(clk_g), .rst_n(rst_n), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(douta0),
    .ready(ready0), .wr_cnt(wr0), .rd_cnt(rd0), .err(err0)
  );

  mem_responder_16x16 #(.INIT_VAL(IV1), .WRITE_FIRST(1'b1)) dut1 (
    .clk_g(clk_g), .rst_n(rst_n), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(douta1),
    .ready(ready1), .wr_cnt(wr1), .rd_cnt(rd1), .err(err1)
  );

  task automatic cyc();
    @(posedge clk_g);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_g);
    #1;
    mem_ena = 1'b0;
    mem_wea = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Bounded: ready must be up within 16 edges of release
  task automatic wait_ready();
    for (int i = 0; i < 16; i++) cyc();
    checks++;
    if (!(ready0 && ready1)) begin
      errors++;
      $display("FAIL wait_ready got=%b%b exp=11", ready0, ready1);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({douta0, douta1, ready0, ready1, wr0, wr1, rd0, rd1, err0, err1}
        !== '0) begin
      errors++;
      $display("FAIL reset_state got d0=%h d1=%h r=%b%b w=%0d/%0d rd=%0d/%0d e=%b%b exp=all0",
               douta0, douta1, ready0, ready1, wr0, wr1, rd0, rd1, err0, err1);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      cyc();
      checks++;
      if ({ready0, ready1} !== ((e < 16) ? 2'b00 : 2'b11)) begin
        errors++;
        $display("FAIL ready_timing edge=%0d got=%b%b exp=%0d",
                 e, ready0, ready1, (e < 16) ? 0 : 1);
      end
    end
    mem_ena = 1'b1;
    mem_wea = 1'b0;
    for (int a = 0; a < 16; a++) begin
      mem_addra = 4'(a);
      cyc();
      checks++;
      if (douta0 !== IV0 || douta1 !== IV1) begin
        errors++;
        $display("FAIL init_read addr=%0d got=%h/%h exp=%h/%h",
                 a, douta0, douta1, IV0, IV1);
      end
    end
    mem_ena = 1'b0;
    cyc();
    checks++;
    if (rd0 !== 8'd16 || wr0 !== 8'd0 || err0 !== 1'b0 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL init_counts got rd=%0d wr=%0d err=%b%b exp rd=16 wr=0 err=00",
               rd0, wr0, err0, err1);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] wv;
    do_reset();
    wait_ready();
    mem_ena = 1'b1;
    mem_wea = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wv = (k == 15) ? 16'hFFFF : 16'((32'd1 << (k + 2)) - 32'd1);
      mem_addra = 4'(k);
      mem_dina = wv;
      cyc();
      checks++;
      if (douta0 !== IV0 || douta1 !== wv) begin
        errors++;
        $display("FAIL write_douta k=%0d got=%h/%h exp=%h/%h",
                 k, douta0, douta1, IV0, wv);
      end
    end
    mem_wea = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wv = (k == 15) ? 16'hFFFF : 16'((32'd1 << (k + 2)) - 32'd1);
      mem_addra = 4'(k);
      cyc();
      checks++;
      if (douta0 !== wv || douta1 !== wv) begin
        errors++;
        $display("FAIL readback k=%0d got=%h/%h exp=%h", k, douta0, douta1, wv);
      end
    end
    mem_ena = 1'b0;
    cyc();
    checks++;
    if (wr0 !== 8'd16 || rd0 !== 8'd16 || wr1 !== 8'd16 || rd1 !== 8'd16) begin
      errors++;
      $display("FAIL wr_rd_counts got wr=%0d/%0d rd=%0d/%0d exp=16",
               wr0, wr1, rd0, rd1);
    end
  endtask

  task automatic test_collision();
    mem_ena = 1'b1;
    mem_wea = 1'b1;
    mem_addra = 4'd5;
    mem_dina = 16'h00AA;
    cyc();
    mem_dina = 16'h0055;
    cyc();
    checks++;
    if (douta0 !== 16'h00AA || douta1 !== 16'h0055) begin
      errors++;
      $display("FAIL collision got=%h/%h exp=00aa/0055", douta0, douta1);
    end
    mem_wea = 1'b0;
    cyc();
    checks++;
    if (douta0 !== 16'h0055 || douta1 !== 16'h0055) begin
      errors++;
      $display("FAIL read_after_write got=%h/%h exp=0055", douta0, douta1);
    end
  endtask

  task automatic test_idle();
    logic [7:0] w_exp, r_exp;
    w_exp = wr0;
    r_exp = rd0;
    mem_ena = 1'b0;
    mem_wea = 1'b1;
    mem_addra = 4'd5;
    mem_dina = 16'hFFFF;
    cyc();
    cyc();
    checks++;
    if (douta0 !== 16'h0055 || douta1 !== 16'h0055 || wr0 !== w_exp ||
        rd0 !== r_exp) begin
      errors++;
      $display("FAIL idle_hold got d=%h/%h wr=%0d rd=%0d exp d=0055 wr=%0d rd=%0d",
               douta0, douta1, wr0, rd0, w_exp, r_exp);
    end
    mem_ena = 1'b1;
    mem_wea = 1'b0;
    mem_addra = 4'd4;
    cyc();
    mem_addra = 4'd5;
    cyc();
    checks++;
    if (douta0 !== 16'h0055 || douta1 !== 16'h0055) begin
      errors++;
      $display("FAIL idle_no_write got=%h/%h exp=0055", douta0, douta1);
    end
    mem_ena = 1'b0;
  endtask

  task automatic test_init_ignore();
    do_reset();
    cyc();
    cyc();
    mem_ena = 1'b1;
    mem_wea = 1'b1;
    mem_addra = 4'd3;
    mem_dina = 16'hBEEF;
    cyc();
    mem_ena = 1'b0;
    mem_wea = 1'b0;
    checks++;
    if (err0 !== 1'b1 || err1 !== 1'b1) begin
      errors++;
      $display("FAIL err_set got=%b%b exp=11", err0, err1);
    end
    for (int i = 0; i < 13; i++) cyc();
    checks++;
    if (ready0 !== 1'b1 || wr0 !== 8'd0 || douta0 !== 16'h0000 ||
        douta1 !== 16'h0000) begin
      errors++;
      $display("FAIL init_ignore got r=%b wr=%0d d=%h/%h exp r=1 wr=0 d=0000",
               ready0, wr0, douta0, douta1);
    end
    mem_ena = 1'b1;
    mem_addra = 4'd3;
    cyc();
    mem_ena = 1'b0;
    cyc();
    cyc();
    checks++;
    if (douta0 !== IV0 || douta1 !== IV1 || err0 !== 1'b1 || err1 !== 1'b1) begin
      errors++;
      $display("FAIL word3_sticky got d=%h/%h err=%b%b exp d=%h/%h err=11",
               douta0, douta1, err0, err1, IV0, IV1);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    wait_ready();
    mem_ena = 1'b1;
    mem_wea = 1'b0;
    for (int i = 0; i < 300; i++) begin
      mem_addra = 4'(i);
      cyc();
      if (i == 254) begin
        checks++;
        if (rd0 !== 8'd255) begin
          errors++;
          $display("FAIL rd_cnt_255 got=%0d exp=255", rd0);
        end
      end
    end
    mem_ena = 1'b0;
    checks++;
    if (rd0 !== 8'd255 || rd1 !== 8'd255 || wr0 !== 8'd0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_saturate got rd=%0d/%0d wr=%0d err=%b exp rd=255 wr=0 err=0",
               rd0, rd1, wr0, err0);
    end
  endtask

  task automatic test_reset_mid();
    mem_ena = 1'b1;
    mem_wea = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_addra = 4'(i);
      mem_dina = 16'hA5A0 + 16'(i);
      cyc();
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({douta0, douta1, ready0, ready1, wr0, wr1, rd0, rd1, err0, err1}
        !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear got d=%h/%h r=%b%b wr=%0d rd=%0d err=%b exp=all0",
               douta0, douta1, ready0, ready1, wr0, rd0, err0);
    end
    cyc();
    mem_ena = 1'b0;
    mem_wea = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    checks++;
    if (ready0 !== 1'b0) begin
      errors++;
      $display("FAIL reinit_ready_early got=%b exp=0", ready0);
    end
    cyc();
    mem_ena = 1'b1;
    for (int a = 0; a < 16; a++) begin
      mem_addra = 4'(a);
      cyc();
      checks++;
      if (douta0 !== IV0 || douta1 !== IV1) begin
        errors++;
        $display("FAIL reinit_read addr=%0d got=%h/%h exp=%h/%h",
                 a, douta0, douta1, IV0, IV1);
      end
    end
    mem_ena = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_idle();
    test_init_ignore();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
